viterbi_dec: RTL and testbench
==============================

Name: viterbi_dec

Overview:
- Hard-decision, rate-1/2, K=7 Viterbi decoder for the symbol stream produced by the team's convolutional encoder.
- Code: G1=171 octal drives symbol bit 0. G2=133 octal drives symbol bit 1, and bit 1 is transmitted inverted.
- Uses a register-exchange survivor memory.
- Sits at the receive end of the link and recovers the data bits, one decoded bit per received symbol pair once the pipeline has filled.

Parameters:
- TB_DEPTH, 32: survivor length in symbols (decision depth); legal range 8..64.
- PM_W, 8: path-metric width in bits; must be at least 5.
- INVERT_G2, 1: when 1, the expected symbol bit 1 is the inverted G2 parity.

Ports:
- clk  in  1  single clock; all logic rises on its posedge.
- rstn  in  1  asynchronous, active-low reset.
- dv_in  in  1  symbol pair valid; may be high on consecutive cycles.
- din  in  2  received symbol pair; bit 0 is the G1 symbol, bit 1 is the G2 symbol (inverted in transmission).
- dv_out  out  1  decoded bit valid, a one-cycle pulse.
- dout  out  1  decoded data bit.

Behaviour:
- Reset: one clock; asynchronous, active-low reset. While rstn=0 the block forces:
  - dv_out=0, dout=0.
  - All survivors to 0, and the fill counter to 0.
  - pm[0]=0 and pm[s]=2^(PM_W-3) for s=1..63.
- Reset mid-stream: dv_out drops immediately and any partial survivors are discarded. Decoding restarts from state 0.
- State convention:
  - S is 6 bits, with S[5] the most recent input bit.
  - For input bit b from state S, the encoder register is R={b,S}.
  - Expected symbol bit 0: e0 = ^(7'b1111001 & R).
  - Expected symbol bit 1: e1 = ^(7'b1011011 & R), inverted when INVERT_G2=1.
  - Next state: S'={b,S[5:1]}.
- Predecessors of S': b=S'[5]; the two predecessors are P0={S'[4:0],1'b0} and P1={S'[4:0],1'b1}.
- Branch metric: Hamming distance between din and {e1,e0}, range 0..2.
- ACS, only on a cycle with dv_in=1:
  - cand_x = pm[Px] + bm_x, computed modulo 2^PM_W.
  - Select x=1 when cand_1 < cand_0 under modular comparison (sign bit of cand_1-cand_0 is 1); ties select x=0.
  - pm'[S'] = cand_x.
  - surv'[S'] = {surv[Px][TB_DEPTH-2:0], b}: bit 0 is the newest bit, bit TB_DEPTH-1 is the oldest.
- Metric width: no explicit normalisation. The hard-decision metric spread is at most 12, so modular arithmetic never aliases when PM_W≥5.
- Fill counter: counts accepted pairs, saturating at TB_DEPTH-1.
- Output stage, on the cycle after an ACS update:
  - Argmin over the registered pm[]; ties go to the lowest state index.
  - When the fill counter had reached TB_DEPTH-1 before this pair, register dout=surv[best][TB_DEPTH-1] and dv_out=1; otherwise dv_out=0.
  - dout holds its value when dv_out=0.
- Latency: dv_out pulses exactly 2 cycles after the accepting dv_in.
- Alignment: for accepted pair index i (0-based), the output exists when i≥TB_DEPTH-1 and carries data bit i-(TB_DEPTH-1).
- dv_in=0 cycles: no state change and no output; gaps of any length are allowed.
- Stream end: no tail handling. Upstream appends 6 zero bits plus TB_DEPTH flush bits to drain the decoder.

Decomposition:
- Shared package viterbi_pkg holds:
  - K=7, NSTATES=64, G1=7'b1111001, G2=7'b1011011.
  - typedef state_t (logic[5:0]).
  - Function exp_sym(b, S, invert), returning the 2-bit expected symbol.
- Sub-module viterbi_acs: one per state, generated 64 times. Combinational add-compare-select producing the new metric and the decision bit. Registers stay in the top level.

Test Plan:
- Zero stream: 100 pairs of din=2'b10 back-to-back.
  - 69 dv_out pulses (100-31), all dout=0.
  - First pulse 2 cycles after pair index 31.
- Loopback: encoder feeding decoder with 2000 PRBS-9 bits plus 38 zero flush bits.
  - Decoded bit i equals source bit i for all 2000 bits.
- Errors: as loopback, with one symbol bit flipped every 20 pairs → zero decoded errors.
- Gapped input: random dv_in duty of 30%, 500 bits.
  - Same decoded sequence as the back-to-back run.
  - dv_out count equals accepted pairs minus 31.
- Reset: rstn pulled low after pair 200 of a loopback run.
  - dv_out=0 within the reset cycle.
  - After release, with the encoder also reset, the first output appears at new pair 31 and matches new bit 0.
- Metric wrap: 20000 error-free loopback pairs with PM_W=5 → zero errors, exercising the modular compare across wrap.

Source files
------------

// File: rtl/viterbi_pkg.sv
// viterbi_pkg: code constants, state type and expected-symbol helper shared
// by the K=7 rate-1/2 hard-decision Viterbi decoder and its ACS cells.
package viterbi_pkg;
    localparam int         K       = 7;
    localparam int         NSTATES = 64;
    localparam logic [6:0] G1      = 7'b1111001;   // 171 octal, symbol bit 0
    localparam logic [6:0] G2      = 7'b1011011;   // 133 octal, symbol bit 1

    typedef logic [K-2:0] state_t;

    // Expected {bit1, bit0} when input bit b is shifted into state s.
    // The encoder register is {b, s}, b being the newest bit.
    function automatic logic [1:0] exp_sym(input logic b, input state_t s,
                                           input logic invert);
        logic [K-1:0] r;
        r = {b, s};
        return {(^(G2 & r)) ^ invert, ^(G1 & r)};
    endfunction
endpackage

// File: rtl/viterbi_dec_acs.sv
// viterbi_acs: combinational add-compare-select for one destination state.
//   i_pm0 / i_pm1 : metrics of predecessors {S'[4:0],0} and {S'[4:0],1}
//   i_din         : received symbol pair
//   o_pm          : surviving metric for STATE
//   o_sel         : 1 when the predecessor ending in 1 survives
module viterbi_acs
    import viterbi_pkg::*;
#(
    parameter int PM_W      = 8,
    parameter int STATE     = 0,
    parameter bit INVERT_G2 = 1'b1
) (
    input  logic [PM_W-1:0] i_pm0,
    input  logic [PM_W-1:0] i_pm1,
    input  logic [1:0]      i_din,
    output logic [PM_W-1:0] o_pm,
    output logic            o_sel
);
    localparam state_t NS = state_t'(STATE);
    localparam logic   B  = NS[5];
    localparam state_t P0 = {NS[4:0], 1'b0};
    localparam state_t P1 = {NS[4:0], 1'b1};

    logic [1:0]      w_x0, w_x1;
    logic [PM_W-1:0] w_c0, w_c1, w_diff;

    // Hamming distance of the received pair to each branch label.
    assign w_x0 = i_din ^ exp_sym(B, P0, INVERT_G2);
    assign w_x1 = i_din ^ exp_sym(B, P1, INVERT_G2);
    assign w_c0 = i_pm0 + PM_W'(w_x0[0]) + PM_W'(w_x0[1]);
    assign w_c1 = i_pm1 + PM_W'(w_x1[0]) + PM_W'(w_x1[1]);

    // Metrics wrap freely; the sign of the modular difference orders them
    // because the live spread stays far below half the metric range.
    assign w_diff = w_c1 - w_c0;
    assign o_sel  = w_diff[PM_W-1];
    assign o_pm   = o_sel ? w_c1 : w_c0;
endmodule

// File: rtl/viterbi_dec.sv
// viterbi_dec: hard-decision rate-1/2 K=7 Viterbi decoder, register-exchange
// survivors of TB_DEPTH bits, one decoded bit per accepted pair once filled.
//   clk, rstn      : clock, asynchronous active-low reset
//   dv_in, din     : received symbol pair and its valid
//   dv_out, dout   : decoded bit (one-cycle valid pulse, dout held otherwise)
module viterbi_dec
    import viterbi_pkg::*;
#(
    parameter int TB_DEPTH  = 32,
    parameter int PM_W      = 8,
    parameter bit INVERT_G2 = 1'b1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       dv_in,
    input  logic [1:0] din,
    output logic       dv_out,
    output logic       dout
);
    localparam int              FC_W     = $clog2(TB_DEPTH);
    localparam logic [FC_W-1:0] FILL_MAX = FC_W'(TB_DEPTH - 1);
    localparam logic [PM_W-1:0] PM_INIT  = PM_W'(2 ** (PM_W - 3));

    logic [NSTATES-1:0][PM_W-1:0]     r_pm, w_pm_nxt;
    logic [NSTATES-1:0][TB_DEPTH-1:0] r_surv, w_surv_nxt;
    logic [NSTATES-1:0]               w_sel;
    logic [FC_W-1:0]                  r_fill;
    logic                             r_out_en;
    logic                             r_dv_out, r_dout;
    state_t                           w_best;
    logic [PM_W-1:0]                  w_min, w_diff;

    for (genvar s = 0; s < NSTATES; s++) begin : g_st
        localparam int   P0 = (s % 32) * 2;
        localparam logic B  = (s >= 32);

        viterbi_acs #(
            .PM_W      (PM_W),
            .STATE     (s),
            .INVERT_G2 (INVERT_G2)
        ) u_acs (
            .i_pm0 (r_pm[P0]),
            .i_pm1 (r_pm[P0+1]),
            .i_din (din),
            .o_pm  (w_pm_nxt[s]),
            .o_sel (w_sel[s])
        );

        // Newest decision enters at bit 0; the oldest falls off the top.
        assign w_surv_nxt[s] = w_sel[s] ? {r_surv[P0+1][TB_DEPTH-2:0], B}
                                        : {r_surv[P0][TB_DEPTH-2:0], B};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int s = 0; s < NSTATES; s++)
                r_pm[s] <= (s == 0) ? '0 : PM_INIT;
            r_surv   <= '0;
            r_fill   <= '0;
            r_out_en <= 1'b0;
        end else begin
            // Output allowed only once TB_DEPTH-1 pairs preceded this one.
            r_out_en <= dv_in && (r_fill == FILL_MAX);
            if (dv_in) begin
                r_pm   <= w_pm_nxt;
                r_surv <= w_surv_nxt;
                if (r_fill != FILL_MAX)
                    r_fill <= r_fill + FC_W'(1);
            end
        end
    end

    // Best state: modular argmin, strict compare keeps the lowest index on ties.
    always_comb begin
        w_best = '0;
        w_min  = r_pm[0];
        w_diff = '0;
        for (int s = 1; s < NSTATES; s++) begin
            w_diff = r_pm[s] - w_min;
            if (w_diff[PM_W-1]) begin
                w_best = state_t'(s);
                w_min  = r_pm[s];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_dv_out <= 1'b0;
            r_dout   <= 1'b0;
        end else begin
            r_dv_out <= r_out_en;
            if (r_out_en)
                r_dout <= r_surv[w_best][TB_DEPTH-1];
        end
    end

    assign dv_out = r_dv_out;
    assign dout   = r_dout;
endmodule

// File: tb/tb_viterbi_dec.sv
// tb_viterbi_dec: random loopback bench. A bench-side convolutional encoder
// feeds both a PM_W=8 and a PM_W=5 decoder; the model expects source bit
// i-31 two cycles after accepted pair i (i>=31) and checks every cycle.
module tb_viterbi_dec;
    localparam int TBD = 32;

    logic       clk, rstn, dv_in;
    logic [1:0] din;
    logic       dv_out_a, dout_a, dv_out_b, dout_b;

    viterbi_dec #(.TB_DEPTH(TBD), .PM_W(8), .INVERT_G2(1'b1)) dut_a (
        .clk(clk), .rstn(rstn), .dv_in(dv_in), .din(din),
        .dv_out(dv_out_a), .dout(dout_a));

    viterbi_dec #(.TB_DEPTH(TBD), .PM_W(5), .INVERT_G2(1'b1)) dut_b (
        .clk(clk), .rstn(rstn), .dv_in(dv_in), .din(din),
        .dv_out(dv_out_b), .dout(dout_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- transmitter side ----------------
    bit         data_hist [0:20200];
    logic [5:0] enc_s;
    logic [8:0] lfsr;
    int         idx;
    bit         run_end, done;

    // Encoder register {b, s}; bit 1 is the inverted 133 parity.
    function automatic logic [1:0] enc(input bit b, input logic [5:0] s);
        logic [6:0] r;
        r = {b, s};
        return {~^(r & 7'o133), ^(r & 7'o171)};
    endfunction

    task automatic prbs(output bit b);
        b    = lfsr[8] ^ lfsr[4];
        lfsr = {lfsr[7:0], b};
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input bit b, input bit flip);
        logic [1:0] s;
        s = enc(b, enc_s);
        if (flip) begin
            if ($urandom_range(0, 1) == 0) s[0] = ~s[0];
            else                           s[1] = ~s[1];
        end
        data_hist[idx] = b;
        idx   = idx + 1;
        enc_s = {b, enc_s[5:1]};
        din   = s;
        dv_in = 1'b1;
        idle(1);
        dv_in = 1'b0;
    endtask

    task automatic run_loop(input int n, input bit errs);
        bit b;
        for (int i = 0; i < n; i++) begin
            prbs(b);
            send(b, errs && (i % 20 == 10));
        end
        for (int i = 0; i < 6 + TBD; i++) send(1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rstn  = 1'b0;
        dv_in = 1'b0;
        idle(1);
        rstn  = 1'b1;
        enc_s = '0;
        idx   = 0;
    endtask

    task automatic finish_run();
        idle(4);
        run_end = 1'b1;
        idle(1);
        run_end = 1'b0;
    endtask

    initial begin
        bit b;
        rstn = 1'b0; dv_in = 1'b0; din = 2'b00;
        run_end = 1'b0; done = 1'b0;
        lfsr = 9'h1ff; enc_s = '0; idx = 0;
        idle(3);
        rstn = 1'b1;

        // all-zero data: symbol pair is constant 2'b10
        for (int i = 0; i < 100; i++) send(1'b0, 1'b0);
        finish_run(); do_reset();

        run_loop(2000, 1'b0);
        finish_run(); do_reset();

        run_loop(2000, 1'b1);
        finish_run(); do_reset();

        // ~30% duty gapped input
        for (int i = 0; i < 500 + 6 + TBD; i++) begin
            if (i < 500) prbs(b);
            else         b = 1'b0;
            while ($urandom_range(0, 9) >= 3) idle(1);
            send(b, 1'b0);
        end
        finish_run(); do_reset();

        // reset right after pair 200, then a fresh stream
        for (int i = 0; i <= 200; i++) begin
            prbs(b);
            send(b, 1'b0);
        end
        do_reset();
        run_loop(150, 1'b0);
        finish_run(); do_reset();

        // long run wraps the 5-bit metrics many times
        run_loop(20000, 1'b0);
        finish_run();

        done = 1'b1;
        idle(4);
    end

    // ---------------- model + compare ----------------
    typedef struct {
        int due;
        bit b;
    } pend_t;

    pend_t pend [$];
    int    ncyc, acc_n, cnt_a, cnt_b, total, bad, exp_cnt;
    bit    exp_v, exp_dout;

    task automatic chk(input string nm, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s cycle=%0d got=%0d want=%0d", nm, ncyc, act, exp);
        end
    endtask

    initial begin
        ncyc = 0; acc_n = 0; cnt_a = 0; cnt_b = 0; total = 0; bad = 0;
        exp_dout = 1'b0;
    end

    always @(negedge clk) begin
        ncyc = ncyc + 1;
        if (ncyc == 1) begin
            chk("enc_b0_s00", int'(enc(1'b0, 6'h00)), 2);
            chk("enc_b1_s00", int'(enc(1'b1, 6'h00)), 1);
            chk("enc_b1_s3f", int'(enc(1'b1, 6'h3f)), 1);
            chk("enc_b0_s02", int'(enc(1'b0, 6'h02)), 0);
        end
        if (!rstn) begin
            pend.delete();
            acc_n = 0; cnt_a = 0; cnt_b = 0;
            exp_dout = 1'b0;
            chk("rst_dv_out_a", int'(dv_out_a), 0);
            chk("rst_dout_a",   int'(dout_a),   0);
            chk("rst_dv_out_b", int'(dv_out_b), 0);
            chk("rst_dout_b",   int'(dout_b),   0);
        end else begin
            exp_v = (pend.size() > 0) && (pend[0].due == ncyc);
            if (exp_v) begin
                exp_dout = pend[0].b;
                void'(pend.pop_front());
            end
            chk("dv_out_a", int'(dv_out_a), int'(exp_v));
            chk("dout_a",   int'(dout_a),   int'(exp_dout));
            chk("dv_out_b", int'(dv_out_b), int'(exp_v));
            chk("dout_b",   int'(dout_b),   int'(exp_dout));
            if (dv_out_a) cnt_a = cnt_a + 1;
            if (dv_out_b) cnt_b = cnt_b + 1;
            if (dv_in) begin
                if (acc_n >= TBD - 1)
                    pend.push_back('{ncyc + 2, data_hist[acc_n - (TBD - 1)]});
                acc_n = acc_n + 1;
            end
            if (run_end) begin
                exp_cnt = (acc_n >= TBD - 1) ? acc_n - (TBD - 1) : 0;
                chk("count_a", cnt_a, exp_cnt);
                chk("count_b", cnt_b, exp_cnt);
            end
        end
        if (ncyc > 95000) begin
            chk("watchdog", 0, 1);
            done = 1'b1;
        end
        if (done) begin
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end
endmodule
